// File: rtl/tone_beacon_tx.sv
// Tone-direction beacon transmitter: turns a 3-bit direction command into a
// square-wave burst whose half-period encodes the direction, then a silent gap.
module tone_beacon_tx #(
  parameter int unsigned HALF_STRAIGHT = 25_000,
  parameter int unsigned HALF_LEFT     = 16_667,
  parameter int unsigned HALF_RIGHT    = 12_500,
  parameter int unsigned HALF_BACK     = 10_000,
  parameter int unsigned BURST_CYCLES  = 25_000_000,
  parameter int unsigned GAP_CYCLES    = 12_500_000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_dir,
  input  logic       abort,
  output logic       cmd_ready,
  output logic       tone_out,
  output logic       busy,
  output logic [2:0] active_dir,
  output logic       done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam logic [2:0] DIR_STOP = 3'b100;

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_cnt_q, half_cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [2:0]       dir_q, dir_d;
  logic             tone_q, tone_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic [2:0]       adir_q, adir_d;
  logic             accept_c;
  logic [CNT_W-1:0] half_sel_c;

  assign accept_c = cmd_valid & ready_q & ~abort;

  // Half-period lookup for the non-STOP directions
  always_comb begin
    half_sel_c = CNT_W'(HALF_STRAIGHT);
    case (cmd_dir[1:0])
      2'b01:   half_sel_c = CNT_W'(HALF_LEFT);
      2'b10:   half_sel_c = CNT_W'(HALF_RIGHT);
      2'b11:   half_sel_c = CNT_W'(HALF_BACK);
      default: half_sel_c = CNT_W'(HALF_STRAIGHT);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    half_cnt_d = half_cnt_q;
    half_d     = half_q;
    dir_d      = dir_q;
    tone_d     = tone_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        tone_d = 1'b0;
        // STOP commands are consumed here without starting a burst
        if (accept_c && !cmd_dir[2]) begin
          state_d    = BURST;
          dir_d      = cmd_dir;
          half_d     = half_sel_c;
          tone_d     = 1'b1;
          cnt_d      = '0;
          half_cnt_d = '0;
        end
      end
      BURST: begin
        if (abort) begin
          state_d    = IDLE;
          tone_d     = 1'b0;
          cnt_d      = '0;
          half_cnt_d = '0;
        end else if (cnt_q == BURST_LAST) begin
          // Burst end truncates whatever half-period is in progress
          cnt_d      = '0;
          half_cnt_d = '0;
          tone_d     = 1'b0;
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (half_cnt_q == half_q - CNT_W'(1)) begin
            tone_d     = ~tone_q;
            half_cnt_d = '0;
          end else begin
            half_cnt_d = half_cnt_q + CNT_W'(1);
          end
        end
      end
      GAP: begin
        tone_d = 1'b0;
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        tone_d     = 1'b0;
        cnt_d      = '0;
        half_cnt_d = '0;
      end
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    adir_d  = busy_d ? dir_d : DIR_STOP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      half_cnt_q <= '0;
      half_q     <= '0;
      dir_q      <= DIR_STOP;
      tone_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      adir_q     <= DIR_STOP;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      half_cnt_q <= half_cnt_d;
      half_q     <= half_d;
      dir_q      <= dir_d;
      tone_q     <= tone_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      adir_q     <= adir_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign tone_out   = tone_q;
  assign busy       = busy_q;
  assign active_dir = adir_q;
  assign done       = done_q;

endmodule

// File: tb/tb_tone_beacon_tx.sv
// Randomized and directed bench for tone_beacon_tx against a cycle-offset
// model: outputs are derived from the number of cycles since acceptance.
module tb_tone_beacon_tx;

  localparam int B = 20;
  localparam int G = 6;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic [2:0] cmd_dir;
  logic       abort;
  logic       cmd_ready;
  logic       tone_out;
  logic       busy;
  logic [2:0] active_dir;
  logic       done;

  int n_vec;
  int n_err;

  // Model: m_t is the 1-based cycle index since the accepting edge
  bit         m_active;
  bit         m_done;
  int         m_t;
  int         m_h;
  logic [2:0] m_dir;

  tone_beacon_tx #(
    .HALF_STRAIGHT(2), .HALF_LEFT(3), .HALF_RIGHT(4), .HALF_BACK(5),
    .BURST_CYCLES(B), .GAP_CYCLES(G), .CNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
    .abort(abort), .cmd_ready(cmd_ready), .tone_out(tone_out), .busy(busy),
    .active_dir(active_dir), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int half_of(input logic [2:0] d);
    case (d[1:0])
      2'b00:   return 2;
      2'b01:   return 3;
      2'b10:   return 4;
      default: return 5;
    endcase
  endfunction

  task automatic check_outputs();
    logic exp_tone;
    exp_tone = m_active && (m_t <= B) && (((m_t - 1) / m_h) % 2 == 0);
    check_eq("tone_out",   32'(tone_out),   32'(exp_tone));
    check_eq("busy",       32'(busy),       32'(m_active));
    check_eq("cmd_ready",  32'(cmd_ready),  32'(!m_active));
    check_eq("active_dir", 32'(active_dir), 32'(m_active ? m_dir : 3'b100));
    check_eq("done",       32'(done),       32'(m_done));
  endtask

  task automatic check_reset_vals();
    check_eq("rst_tone_out",   32'(tone_out),   32'd0);
    check_eq("rst_busy",       32'(busy),       32'd0);
    check_eq("rst_cmd_ready",  32'(cmd_ready),  32'd1);
    check_eq("rst_active_dir", 32'(active_dir), 32'd4);
    check_eq("rst_done",       32'(done),       32'd0);
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_t      = 0;
    m_h      = 1;
    m_dir    = 3'b100;
  endtask

  task automatic model_edge(input logic cv, input logic [2:0] cd, input logic ab);
    if (!m_active) begin
      m_done = 1'b0;
      if (cv && !ab && !cd[2]) begin
        m_active = 1'b1;
        m_t      = 1;
        m_dir    = cd;
        m_h      = half_of(cd);
      end
    end else if (ab) begin
      m_active = 1'b0;
      m_done   = 1'b0;
    end else begin
      m_t++;
      m_done = 1'b0;
      if (m_t > B + G) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
  endtask

  // Called just after a falling edge: check, drive, clock, update model
  task automatic step(input logic cv, input logic [2:0] cd, input logic ab);
    check_outputs();
    cmd_valid = cv;
    cmd_dir   = cd;
    abort     = ab;
    @(posedge clk);
    model_edge(cv, cd, ab);
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'($urandom_range(0, 7)), 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_dir   = 3'b000;
    abort     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    idle_steps(5);

    // LEFT burst with gap and done pulse
    step(1'b1, 3'b001, 1'b0);
    idle_steps(30);

    // STRAIGHT and RIGHT, then BACK followed back-to-back by STRAIGHT
    step(1'b1, 3'b000, 1'b0);
    idle_steps(28);
    step(1'b1, 3'b010, 1'b0);
    idle_steps(28);
    step(1'b1, 3'b011, 1'b0);
    for (int i = 0; i < B + G; i++) step(1'b1, 3'($urandom_range(0, 7)), 1'b0);
    check_eq("b2b_done", 32'(done), 32'd1);
    step(1'b1, 3'b000, 1'b0);
    check_eq("b2b_busy", 32'(busy), 32'd1);
    idle_steps(28);

    // STOP-class command is consumed without a burst
    for (int i = 0; i < 4; i++) step(1'b1, 3'b101, 1'b0);
    idle_steps(3);

    // Abort at burst cycle 7, then abort together with a valid command
    step(1'b1, 3'b010, 1'b0);
    idle_steps(6);
    step(1'b0, 3'b000, 1'b1);
    step(1'b1, 3'b001, 1'b1);
    idle_steps(3);

    // Abort during the gap
    step(1'b1, 3'b001, 1'b0);
    idle_steps(B + 2);
    step(1'b0, 3'b000, 1'b1);
    idle_steps(3);

    // Asynchronous reset at burst cycle 10, between clock edges
    step(1'b1, 3'b011, 1'b0);
    idle_steps(9);
    check_outputs();
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    model_reset();
    cmd_valid = 1'b0;
    @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    step(1'b1, 3'b001, 1'b0);
    idle_steps(30);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 39) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
